// File: rtl/vc_scheduler_if.sv
// vc_scheduler_if: VC FIFO heads, destination FIFO pushes and status of the VC scheduler
interface vc_scheduler_if #(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 8
);
    logic              enable;
    logic [4:0]        fifo_error;
    logic              vc0_empty;
    logic              vc1_empty;
    logic [DATA_W-1:0] vc0_data;
    logic [DATA_W-1:0] vc1_data;
    logic              d0_almost_full;
    logic              d1_almost_full;
    logic              vc0_pop;
    logic              vc1_pop;
    logic              d0_push;
    logic              d1_push;
    logic [DATA_W-1:0] d_data;
    logic              halted;
    logic [CNT_W-1:0]  vc0_served;
    logic [CNT_W-1:0]  vc1_served;

    modport master (
        input  enable, fifo_error, vc0_empty, vc1_empty, vc0_data, vc1_data,
               d0_almost_full, d1_almost_full,
        output vc0_pop, vc1_pop, d0_push, d1_push, d_data, halted, vc0_served, vc1_served
    );

    modport slave (
        output enable, fifo_error, vc0_empty, vc1_empty, vc0_data, vc1_data,
               d0_almost_full, d1_almost_full,
        input  vc0_pop, vc1_pop, d0_push, d1_push, d_data, halted, vc0_served, vc1_served
    );
endinterface

// File: rtl/vc_scheduler.sv
// vc_scheduler: weighted round-robin mover from VC0/VC1 FIFOs into destination FIFOs D0/D1
module vc_scheduler #(
    parameter int DATA_W     = 6,
    parameter int DEST_BIT   = 4,
    parameter int VC0_WEIGHT = 4,
    parameter int CNT_W      = 8
) (
    input logic           clk,
    input logic           reset,
    vc_scheduler_if.master bus
);
    typedef enum logic [1:0] {IDLE, SERVE, ERROR} state_t;
    localparam logic [3:0] W = 4'(VC0_WEIGHT);
    state_t state, state_nx;
    logic [3:0] wcnt;
    logic e0, e1, go, g0, g1, dest;
    logic [DATA_W-1:0] head;
    assign bus.vc0_pop = g0 && !reset;
    assign bus.vc1_pop = g1 && !reset;
    assign bus.halted  = state == ERROR;
    // eligibility, weighted grant and next state; errors mask grants in the same cycle
    always_comb begin
        e0 = !bus.vc0_empty && !(bus.vc0_data[DEST_BIT] ? bus.d1_almost_full : bus.d0_almost_full);
        e1 = !bus.vc1_empty && !(bus.vc1_data[DEST_BIT] ? bus.d1_almost_full : bus.d0_almost_full);
        go = state == SERVE && bus.enable && bus.fifo_error == '0;
        g1 = go && e1 && (!e0 || wcnt == W);
        g0 = go && e0 && !g1;
        head = g1 ? bus.vc1_data : bus.vc0_data;
        dest = head[DEST_BIT];
        state_nx = bus.fifo_error != '0       ? ERROR :
                   state == IDLE && bus.enable  ? SERVE :
                   state == SERVE && !bus.enable ? IDLE  : state;
    end
    // state, registered push of the granted word, weight counter and served counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            wcnt           <= '0;
            bus.d0_push    <= 1'b0;
            bus.d1_push    <= 1'b0;
            bus.d_data     <= '0;
            bus.vc0_served <= '0;
            bus.vc1_served <= '0;
        end else begin
            state       <= state_nx;
            bus.d0_push <= (g0 || g1) && !dest;
            bus.d1_push <= (g0 || g1) && dest;
            if (g0 || g1) bus.d_data <= head;
            wcnt <= g1 ? 4'd0 : g0 && wcnt != W ? wcnt + 4'd1 : wcnt;
            if (g0) bus.vc0_served <= bus.vc0_served + CNT_W'(1);
            if (g1) bus.vc1_served <= bus.vc1_served + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_vc_scheduler.sv
// tb_vc_scheduler: directed and random checks of vc_scheduler against a queue-based reference model
module tb_vc_scheduler;
    localparam int DW = 6, DB = 4, W = 4, CW = 8;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vc_scheduler_if #(.DATA_W(DW), .CNT_W(CW)) bus();
    vc_scheduler #(.DATA_W(DW), .DEST_BIT(DB), .VC0_WEIGHT(W), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    logic [DW-1:0] q0[$], q1[$];
    logic en = 1'b0, af0 = 1'b0, af1 = 1'b0;
    logic [4:0] ferr = '0;
    int ntests = 0, nfail = 0;
    int mst, streak, ms0, ms1;
    logic run, e0, e1, mg0, mg1, mp0, mp1;
    logic [DW-1:0] md;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic elig(input int n, input logic [DW-1:0] h);
        return n > 0 && !(h[DB] ? af1 : af0);
    endfunction

    task automatic drive();
        bus.enable         = en;
        bus.fifo_error     = ferr;
        bus.d0_almost_full = af0;
        bus.d1_almost_full = af1;
        bus.vc0_empty      = q0.size() == 0;
        bus.vc1_empty      = q1.size() == 0;
        bus.vc0_data       = q0.size() > 0 ? q0[0] : '0;
        bus.vc1_data       = q1.size() > 0 ? q1[0] : '0;
    endtask

    task automatic model_reset();
        mst = 0; streak = 0; ms0 = 0; ms1 = 0;
        mp0 = 1'b0; mp1 = 1'b0; md = '0;
    endtask

    task automatic cyc();
        drive();
        #1;
        e0  = elig(q0.size(), bus.vc0_data);
        e1  = elig(q1.size(), bus.vc1_data);
        run = mst == 1 && en && ferr == 0;
        mg1 = run && e1 && (!e0 || streak == W);
        mg0 = run && e0 && !mg1;
        chk("vc0_pop", bus.vc0_pop, mg0);
        chk("vc1_pop", bus.vc1_pop, mg1);
        @(posedge clk);
        mp0 = 1'b0; mp1 = 1'b0;
        if (mg0) begin md = q0.pop_front(); ms0++; streak = streak < W ? streak + 1 : W; end
        if (mg1) begin md = q1.pop_front(); ms1++; streak = 0; end
        if (mg0 || mg1) begin mp0 = !md[DB]; mp1 = md[DB]; end
        mst = ferr != 0 ? 2 : (mst == 0 && en) ? 1 : (mst == 1 && !en) ? 0 : mst;
        @(negedge clk);
        chk("d0_push", bus.d0_push, mp0);
        chk("d1_push", bus.d1_push, mp1);
        chk("d_data", bus.d_data, md);
        chk("vc0_served", bus.vc0_served, ms0 % 256);
        chk("vc1_served", bus.vc1_served, ms1 % 256);
        chk("halted", bus.halted, mst == 2);
    endtask

    task automatic do_reset();
        drive();
        reset = 1'b1;
        #1;
        chk("rst_vc0_pop", bus.vc0_pop, 0);
        chk("rst_vc1_pop", bus.vc1_pop, 0);
        chk("rst_push", {bus.d0_push, bus.d1_push}, 0);
        chk("rst_d_data", bus.d_data, 0);
        chk("rst_halted", bus.halted, 0);
        chk("rst_served", {bus.vc0_served, bus.vc1_served}, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        // three VC0 words to D0, VC1 empty
        do_reset();
        q0 = '{6'h01, 6'h02, 6'h03};
        en = 1'b1;
        repeat (5) cyc();
        chk("s1_vc0_served", bus.vc0_served, 3);
        // both VCs backlogged: 4:1 weighting
        do_reset();
        for (int i = 0; i < 12; i++) begin
            q0.push_back(DW'($urandom));
            q1.push_back(DW'($urandom));
        end
        repeat (11) cyc();
        chk("s2_vc0_served", bus.vc0_served, 8);
        chk("s2_vc1_served", bus.vc1_served, 2);
        // VC0 blocked by D1 almost-full, VC1 flows
        do_reset();
        q0.delete(); q1.delete();
        for (int i = 0; i < 6; i++) q0.push_back(DW'(6'h10 | i));
        for (int i = 0; i < 10; i++) q1.push_back(DW'(i));
        af1 = 1'b1;
        repeat (6) cyc();
        chk("s3_vc0_blocked", bus.vc0_served, 0);
        af1 = 1'b0;
        cyc();
        chk("s3_vc0_unblocked", bus.vc0_served, 1);
        // enable low for two cycles mid-stream
        repeat (3) cyc();
        en = 1'b0;
        repeat (2) cyc();
        en = 1'b1;
        repeat (6) cyc();
        // random traffic, back-pressure and enable toggles
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (q0.size() < 8 && $urandom_range(0, 2) != 0) q0.push_back(DW'($urandom));
            if (q1.size() < 8 && $urandom_range(0, 2) != 0) q1.push_back(DW'($urandom));
            af0 = $urandom_range(0, 3) == 0;
            af1 = $urandom_range(0, 3) == 0;
            en  = $urandom_range(0, 15) != 0;
            cyc();
        end
        // one-cycle FIFO error halts until reset
        af0 = 1'b0; af1 = 1'b0; en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            q0.push_back(DW'($urandom));
            q1.push_back(DW'($urandom));
        end
        repeat (3) cyc();
        ferr = 5'b00100;
        cyc();
        ferr = '0;
        repeat (5) cyc();
        chk("err_sticky", bus.halted, 1);
        do_reset();
        // VC0 served counter wraps
        q0.delete(); q1.delete();
        for (int i = 0; i < 256; i++) q0.push_back(DW'(i & 6'h0f));
        repeat (256) cyc();
        chk("wrap_255", bus.vc0_served, 255);
        cyc();
        chk("wrap_0", bus.vc0_served, 0);
        chk("wrap_vc1", bus.vc1_served, 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/vc_scheduler.md
Name: vc_scheduler

Overview:
Weighted round-robin scheduler that moves words from the two virtual-channel FIFOs (VC0, VC1) into the two destination FIFOs (D0, D1). It sits between the VC FIFO outputs and the destination FIFO inputs, and runs only while the link-level state machine reports the datapath active. The block honours destination almost-full back-pressure, halts on any FIFO error, and keeps per-VC served-word counters.

Parameters:
DATA_W, 6, word width of VC and destination FIFOs
DEST_BIT, 4, bit index in the head word that selects the destination (0 -> D0, 1 -> D1); must be < DATA_W
VC0_WEIGHT, 4, maximum consecutive VC0 grants while VC1 is eligible; range 1..15
CNT_W, 8, width of the served-word counters

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  scheduling permitted (driven from the link FSM active indication)
fifo_error  input  5  per-FIFO error flags; any nonzero value halts scheduling
vc0_empty  input  1  VC0 FIFO empty
vc1_empty  input  1  VC1 FIFO empty
vc0_data  input  DATA_W  VC0 head word (first-word-fall-through, valid when !vc0_empty)
vc1_data  input  DATA_W  VC1 head word (FWFT)
d0_almost_full  input  1  D0 FIFO almost full (threshold leaves >=2 free entries)
d1_almost_full  input  1  D1 FIFO almost full
vc0_pop  output  1  pop VC0 head this cycle (combinational)
vc1_pop  output  1  pop VC1 head this cycle (combinational)
d0_push  output  1  push d_data into D0 (registered)
d1_push  output  1  push d_data into D1 (registered)
d_data  output  DATA_W  word being pushed (registered)
halted  output  1  scheduler in ERROR state (registered)
vc0_served  output  CNT_W  count of words moved from VC0, wrapping
vc1_served  output  CNT_W  count of words moved from VC1, wrapping

Behaviour:
- Reset (asynchronous, on reset=1): state=IDLE; d0_push=d1_push=0; d_data=0; halted=0; weight counter=0; vc0_served=vc1_served=0. The pop outputs are forced to 0 while reset=1.
- Eligibility: VCn is eligible when !vcn_empty and the destination selected by vcn_data[DEST_BIT] has almost_full=0.
- States:
  - IDLE: no grants. Go to SERVE when enable=1 and fifo_error==0.
  - SERVE: at most one grant per cycle. Go to IDLE when enable=0. Go to ERROR when fifo_error!=0.
  - ERROR: sticky; no grants; halted=1. Left only via reset.
- Error precedence: fifo_error!=0 in any state sends the block to ERROR on the next edge and masks the pops combinationally in the same cycle.
- Grant rule (SERVE, fifo_error==0, enable=1):
  - Only VC0 eligible: grant VC0.
  - Only VC1 eligible: grant VC1.
  - Both eligible: grant VC1 if wcnt==VC0_WEIGHT, otherwise grant VC0.
- Weight counter (wcnt, 4 bits): a VC0 grant increments it, saturating at VC0_WEIGHT. A VC1 grant clears it to 0. A cycle with no grant holds it.
- Grant n drives vcn_pop=1 in the same cycle.
- Latency: on the next edge, d_data<=granted head word, the selected dN_push<=1, and vcn_served increments modulo 2^CNT_W. Push outputs are 0 in every cycle that follows a no-grant cycle; d_data holds its last value.
- Back-pressure: almost-full is sampled at grant time. The one in-flight registered push is covered by the >=2-entry threshold margin.
- Both VC heads may target the same destination; one grant per cycle prevents a double push.
- enable falling mid-stream: the push from the grant issued in the cycle before the fall still completes; no new pop in the cycle enable=0.
- Reset mid-operation: a pending push is discarded and the counters clear immediately.

Test Plan:
- Reset, then enable=1. VC0 holds 3 words targeting D0 (0x01,0x02,0x03); VC1 empty. Required: vc0_pop high for 3 consecutive cycles; d0_push high the following 3 cycles with d_data 0x01,0x02,0x03; vc0_served=3.
- Both VCs continuously non-empty, all destinations free, VC0_WEIGHT=4. Required: grant pattern VC0,VC0,VC0,VC0,VC1 repeating; after 10 grants vc0_served=8, vc1_served=2.
- VC0 head targets D1 (bit4=1) with d1_almost_full=1; VC1 head targets D0. Required: VC1 granted every cycle and VC0 never popped. Drop d1_almost_full: VC0 granted on the next cycle.
- During streaming, fifo_error=5'b00100 for 1 cycle. Required: pops=0 in that same cycle; halted=1 from the next edge; no further pops or pushes after the in-flight one, even after fifo_error returns to 0, until reset. reset=1 returns halted=0 asynchronously.
- enable toggled low for 2 cycles mid-stream. Required: no pops while enable=0; exactly one push completes after the fall; scheduling resumes the cycle after enable=1 with wcnt unchanged.
- Preset 255 words through VC0 (vc0_served=255), then move 1 more. Required: vc0_served wraps to 0; vc1_served unaffected.
